// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared ALU control codes and multiply sequencer state encoding
package mips_ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_LUI  = 4'd3;
  localparam logic [3:0] ALU_SRA  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_ORI  = 4'd8;
  localparam logic [3:0] ALU_SRAV = 4'd9;
  localparam logic [3:0] ALU_MUL  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - iterative radix-2 shift-add multiplier that stalls PC/IF while it runs
module mul_seq_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             abort_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mul_state_t state, state_nxt;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_add;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   mplier_shr;
  logic [CW-1:0]      cnt;
  logic               last_iter;

  assign acc_add    = mplier[0] ? (acc + mcand) : acc;
  assign mplier_shr = mplier >> 1;
  // Early exit once the remaining multiplier bits (after this step) are all zero.
  assign last_iter  = (cnt == CNT_LAST) || (EARLY_TERM && (mplier_shr == '0));

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort_i) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start_i) state_nxt = ST_BUSY;
        ST_BUSY: if (last_iter) state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o  = (state == ST_BUSY);
    stall_o = ~rst_i & ~abort_i &
              (((state == ST_IDLE) & start_i) | (state == ST_BUSY));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      valid_o  <= 1'b0;
      result_o <= '0;
      hi_o     <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i && !abort_i) begin
            mcand  <= {{WIDTH{1'b0}}, src1_i};
            mplier <= src2_i;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        ST_BUSY: begin
          acc    <= acc_add;
          mcand  <= mcand << 1;
          mplier <= mplier_shr;
          cnt    <= cnt + CW'(1);
          // Result is captured together with the final accumulate, so it is stable throughout DONE.
          if (!abort_i && last_iter) begin
            valid_o  <= 1'b1;
            result_o <= acc_add[WIDTH-1:0];
            hi_o     <= acc_add[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - directed vector bench for mul_seq_ctrl with early-term on and off
module tb_mul_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] src1;
  logic [31:0] src2;

  logic        stall1, busy1, valid1;
  logic [31:0] res1, hi1;
  logic        stall0, busy0, valid0;
  logic [31:0] res0, hi0;

  int n_vec;
  int n_bad;

  mul_seq_ctrl #(.WIDTH(32), .EARLY_TERM(1'b1)) dut_et1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .src1_i(src1), .src2_i(src2),
    .abort_i(abort), .stall_o(stall1), .busy_o(busy1), .valid_o(valid1),
    .result_o(res1), .hi_o(hi1)
  );

  mul_seq_ctrl #(.WIDTH(32), .EARLY_TERM(1'b0)) dut_et0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .src1_i(src1), .src2_i(src2),
    .abort_i(abort), .stall_o(stall0), .busy_o(busy0), .valid_o(valid0),
    .result_o(res0), .hi_o(hi0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          n;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_cycles(input int k);
    start = 1'b0;
    abort = 1'b0;
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1; cycle 0 is the cycle in which start is presented.
  task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] lo, input logic [31:0] hi);
    int v1, v0, s1, s0, p1, p0;
    logic [31:0] l1, h1, l0, h0;
    v1 = -1; v0 = -1; s1 = 0; s0 = 0; p1 = 0; p0 = 0;
    l1 = 'x; h1 = 'x; l0 = 'x; h0 = 'x;
    start = 1'b1; src1 = a; src2 = b;
    for (int c = 0; c <= 40; c++) begin
      #3;
      if (stall1) s1++;
      if (stall0) s0++;
      if (valid1) begin p1++; if (v1 < 0) begin v1 = c; l1 = res1; h1 = hi1; end end
      if (valid0) begin p0++; if (v0 < 0) begin v0 = c; l0 = res0; h0 = hi0; end end
      @(posedge clk); #1;
      if (c == 0) begin start = 1'b0; src1 = $urandom; src2 = $urandom; end
    end
    check($sformatf("v%0d_et1_valid_cycle", id), 64'(v1), 64'(n + 1));
    check($sformatf("v%0d_et1_stall_cycles", id), 64'(s1), 64'(n + 1));
    check($sformatf("v%0d_et1_pulses", id), 64'(p1), 64'd1);
    check($sformatf("v%0d_et1_lo", id), 64'(l1), 64'(lo));
    check($sformatf("v%0d_et1_hi", id), 64'(h1), 64'(hi));
    check($sformatf("v%0d_et0_valid_cycle", id), 64'(v0), 64'd33);
    check($sformatf("v%0d_et0_stall_cycles", id), 64'(s0), 64'd33);
    check($sformatf("v%0d_et0_pulses", id), 64'(p0), 64'd1);
    check($sformatf("v%0d_et0_lo", id), 64'(l0), 64'(lo));
    check($sformatf("v%0d_et0_hi", id), 64'(h0), 64'(hi));
  endtask

  initial begin
    int p1, v1a, v1b, s4, s5;
    logic [31:0] r1a, r1b;

    n_vec = 0; n_bad = 0;
    clk = 1'b0; rst = 1'b1; start = 1'b1; abort = 1'b0; src1 = 32'd5; src2 = 32'd5;

    vecs[0] = '{32'd6,        32'd7,        3,  32'd42,       32'd0};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'h00000001, 32'hFFFFFFFE};
    vecs[2] = '{32'h1234,     32'd0,        1,  32'd0,        32'd0};
    vecs[3] = '{32'd3,        32'd5,        3,  32'd15,       32'd0};
    vecs[4] = '{32'h10000,    32'h10000,    17, 32'd0,        32'd1};
    vecs[5] = '{32'hFFFFFFFF, 32'd2,        2,  32'hFFFFFFFE, 32'd1};
    vecs[6] = '{32'd0,        32'hFFFFFFFF, 32, 32'd0,        32'd0};
    vecs[7] = '{32'h12345678, 32'd1,        1,  32'h12345678, 32'd0};
    vecs[8] = '{32'h80000000, 32'h80000000, 32, 32'd0,        32'h40000000};
    vecs[9] = '{32'd100,      32'h100,      9,  32'h6400,     32'd0};

    // Reset state, with start high to confirm stall is held low during reset.
    repeat (2) @(posedge clk);
    #3;
    check("rst_stall_et1", 64'(stall1), 64'd0);
    check("rst_busy_et1", 64'(busy1), 64'd0);
    check("rst_valid_et1", 64'(valid1), 64'd0);
    check("rst_result_et1", 64'(res1), 64'd0);
    check("rst_hi_et1", 64'(hi1), 64'd0);
    check("rst_stall_et0", 64'(stall0), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      run_op(i, vecs[i].a, vecs[i].b, vecs[i].n, vecs[i].lo, vecs[i].hi);

    // start held through DONE, dropped in the following IDLE cycle: one pulse only.
    p1 = 0; v1a = -1; r1a = 'x;
    start = 1'b1; src1 = 32'd6; src2 = 32'd7;
    for (int c = 0; c <= 12; c++) begin
      #3;
      if (valid1) begin p1++; if (v1a < 0) begin v1a = c; r1a = res1; end end
      @(posedge clk); #1;
      if (c == 4) start = 1'b0;
    end
    check("hold_pulses", 64'(p1), 64'd1);
    check("hold_valid_cycle", 64'(v1a), 64'd4);
    check("hold_result", 64'(r1a), 64'd42);
    idle_cycles(40);

    // Back-to-back: new start in the IDLE cycle right after DONE.
    p1 = 0; v1a = -1; v1b = -1; r1a = 'x; r1b = 'x; s4 = -1; s5 = -1;
    start = 1'b1; src1 = 32'd6; src2 = 32'd7;
    for (int c = 0; c <= 14; c++) begin
      #3;
      if (c == 4) s4 = int'(stall1);
      if (c == 5) s5 = int'(stall1);
      if (valid1) begin
        p1++;
        if (v1a < 0) begin v1a = c; r1a = res1; end
        else if (v1b < 0) begin v1b = c; r1b = res1; end
      end
      @(posedge clk); #1;
      if (c == 4) begin src1 = 32'd3; src2 = 32'd5; end
      if (c == 5) start = 1'b0;
    end
    check("b2b_pulses", 64'(p1), 64'd2);
    check("b2b_first_cycle", 64'(v1a), 64'd4);
    check("b2b_first_result", 64'(r1a), 64'd42);
    check("b2b_second_cycle", 64'(v1b), 64'd9);
    check("b2b_second_result", 64'(r1b), 64'd15);
    check("b2b_stall_done", 64'(s4), 64'd0);
    check("b2b_stall_restart", 64'(s5), 64'd1);
    idle_cycles(40);

    // Abort in cycle 5 of a long operation.
    p1 = 0;
    start = 1'b1; src1 = 32'h80000000; src2 = 32'h80000000;
    for (int c = 0; c <= 40; c++) begin
      #3;
      if (c == 5) begin
        check("abort_stall_et1", 64'(stall1), 64'd0);
        check("abort_stall_et0", 64'(stall0), 64'd0);
      end
      if (c == 6) begin
        check("abort_idle_et1", 64'(busy1), 64'd0);
        check("abort_idle_et0", 64'(busy0), 64'd0);
      end
      if (valid1 || valid0) p1++;
      @(posedge clk); #1;
      if (c == 0) start = 1'b0;
      if (c == 4) abort = 1'b1;
      if (c == 5) abort = 1'b0;
    end
    check("abort_no_valid", 64'(p1), 64'd0);
    check("abort_result_kept_et1", 64'(res1), 64'd15);
    check("abort_hi_kept_et1", 64'(hi1), 64'd0);
    check("abort_result_kept_et0", 64'(res0), 64'd42);

    // Reset in the middle of BUSY, then a fresh multiply.
    start = 1'b1; src1 = 32'h80000000; src2 = 32'h80000000;
    for (int c = 0; c <= 11; c++) begin
      #3;
      if (c == 10) check("midrst_stall", 64'(stall1), 64'd0);
      if (c == 11) begin
        check("midrst_busy_et1", 64'(busy1), 64'd0);
        check("midrst_valid_et1", 64'(valid1), 64'd0);
        check("midrst_result_et1", 64'(res1), 64'd0);
        check("midrst_hi_et1", 64'(hi1), 64'd0);
        check("midrst_busy_et0", 64'(busy0), 64'd0);
        check("midrst_result_et0", 64'(res0), 64'd0);
        check("midrst_stall_idle", 64'(stall1), 64'd0);
      end
      @(posedge clk); #1;
      if (c == 0) start = 1'b0;
      if (c == 9) rst = 1'b1;
      if (c == 10) rst = 1'b0;
    end
    run_op(99, 32'd2, 32'd3, 2, 32'd6, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
